// File: rtl/proc_pkg.sv
// Shared pipeline types and forwarding-select codes for the EX forwarding/hazard control.
package proc_pkg;

    localparam int REG_AW = 5;
    localparam int SEL_W  = 2;

    // Codes line up with the mux33 data inputs d0/d1/d2.
    localparam logic [SEL_W-1:0] FWD_RF  = 2'b00;
    localparam logic [SEL_W-1:0] FWD_WB  = 2'b01;
    localparam logic [SEL_W-1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] dst;
        logic              rw;
        logic              ld;
    } ex_slot_t;

    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] dst;
        logic              rw;
    } wr_slot_t;

    // r0 is hardwired to zero, so a write to it is never a forwarding source.
    function automatic logic slot_hits(input wr_slot_t s, input logic [REG_AW-1:0] src);
        return s.v & s.rw & (s.dst != '0) & (s.dst == src);
    endfunction

endpackage

// File: rtl/fwd_sel_unit.sv
// Combinational forwarding select for one EX operand; MEM result beats WB result.
module fwd_sel_unit
    import proc_pkg::*;
(
    input  logic              ex_v,
    input  logic [REG_AW-1:0] src,
    input  wr_slot_t          mem_slot,
    input  wr_slot_t          wb_slot,
    output logic [SEL_W-1:0]  sel
);

    always_comb begin
        sel = FWD_RF;
        if (ex_v) begin
            if (slot_hits(mem_slot, src)) begin
                sel = FWD_MEM;
            end else if (slot_hits(wb_slot, src)) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// EX/MEM/WB destination tracking, operand forwarding selects and load-use stall/flush control.
// Optional statistics counters are enabled by defining FWD_HAZARD_STATS_EN.
module fwd_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int SEL_W  = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              id_regwrite,
    input  logic              id_load,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              branch_flush,
    input  logic              mem_stall,
    output logic [SEL_W-1:0]  fwd_a_s,
    output logic [SEL_W-1:0]  fwd_b_s,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_e
`ifdef FWD_HAZARD_STATS_EN
    ,
    output logic [15:0]       stat_stall_cnt,
    output logic [15:0]       stat_fwd_mem_cnt,
    output logic [15:0]       stat_fwd_wb_cnt
`endif
);
    import proc_pkg::*;

    ex_slot_t ex_q, ex_d;
    wr_slot_t mem_q, mem_d;
    wr_slot_t wb_q, wb_d;

    logic load_use;
    logic stall_c, flush_c;

    assign load_use = id_valid & ex_q.v & ex_q.ld & (ex_q.dst != '0) &
                      ((id_uses_rs & (id_rs == ex_q.dst)) |
                       (id_uses_rt & (id_rt == ex_q.dst)));

    always_comb begin
        ex_d    = ex_q;
        mem_d   = mem_q;
        wb_d    = wb_q;
        stall_c = 1'b0;
        flush_c = 1'b0;
        if (mem_stall) begin
            stall_c = 1'b1;
        end else begin
            mem_d = '{v: ex_q.v, dst: ex_q.dst, rw: ex_q.rw};
            wb_d  = mem_q;
            // A taken branch kills the decode instruction, which also cancels any load-use stall on it.
            if (branch_flush) begin
                flush_c = 1'b1;
                ex_d    = '0;
            end else if (load_use) begin
                stall_c = 1'b1;
                flush_c = 1'b1;
                ex_d    = '0;
            end else begin
                ex_d = '{v: id_valid, rs: id_rs, rt: id_rt, dst: id_dst,
                         rw: id_regwrite, ld: id_load};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    // mem_stall is a raw input, so the controls are masked to stay quiet during reset.
    assign stall_f = reset_n & stall_c;
    assign stall_d = reset_n & stall_c;
    assign flush_e = reset_n & flush_c;

    fwd_sel_unit u_fwd_a (
        .ex_v     (ex_q.v),
        .src      (ex_q.rs),
        .mem_slot (mem_q),
        .wb_slot  (wb_q),
        .sel      (fwd_a_s)
    );

    fwd_sel_unit u_fwd_b (
        .ex_v     (ex_q.v),
        .src      (ex_q.rt),
        .mem_slot (mem_q),
        .wb_slot  (wb_q),
        .sel      (fwd_b_s)
    );

`ifdef FWD_HAZARD_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] mem_cnt_q, mem_cnt_d;
    logic [15:0] wb_cnt_q, wb_cnt_d;

    function automatic logic [15:0] sat_inc(input logic [15:0] c, input logic en);
        return (en && (c != 16'hFFFF)) ? c + 16'd1 : c;
    endfunction

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        mem_cnt_d   = mem_cnt_q;
        wb_cnt_d    = wb_cnt_q;
        if (!mem_stall) begin
            stall_cnt_d = sat_inc(stall_cnt_q, load_use & ~branch_flush);
            mem_cnt_d   = sat_inc(mem_cnt_q, (fwd_a_s == FWD_MEM) | (fwd_b_s == FWD_MEM));
            wb_cnt_d    = sat_inc(wb_cnt_q, (fwd_a_s == FWD_WB) | (fwd_b_s == FWD_WB));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
            mem_cnt_q   <= '0;
            wb_cnt_q    <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            mem_cnt_q   <= mem_cnt_d;
            wb_cnt_q    <= wb_cnt_d;
        end
    end

    assign stat_stall_cnt   = stall_cnt_q;
    assign stat_fwd_mem_cnt = mem_cnt_q;
    assign stat_fwd_wb_cnt  = wb_cnt_q;
`endif

endmodule
